// File: rtl/ram_bundle_pkg.sv
// Shared widths, FSM state encoding and legal write-strobe patterns for the CPU RAM bundle.
package ram_bundle_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned AddrWidth = 32;
  localparam int unsigned WordSize  = 4;
  localparam int unsigned ByteBits  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [WordSize-1:0] STRB_B0  = 4'b0001;
  localparam logic [WordSize-1:0] STRB_B1  = 4'b0010;
  localparam logic [WordSize-1:0] STRB_B2  = 4'b0100;
  localparam logic [WordSize-1:0] STRB_B3  = 4'b1000;
  localparam logic [WordSize-1:0] STRB_HLO = 4'b0011;
  localparam logic [WordSize-1:0] STRB_HHI = 4'b1100;
  localparam logic [WordSize-1:0] STRB_W   = 4'b1111;

  // Strobe is a legal byte/half/word pattern whose lanes agree with the byte offset.
  function automatic logic strobe_legal(input logic [WordSize-1:0] strb, input logic [1:0] ofs);
    logic ok;
    ok = 1'b0;
    case (strb)
      '0:                                  ok = 1'b1;
      STRB_B0, STRB_B1, STRB_B2, STRB_B3:  ok = (strb == (WordSize'(1) << ofs));
      STRB_HLO:                            ok = (ofs == 2'd0);
      STRB_HHI:                            ok = (ofs == 2'd2);
      STRB_W:                              ok = (ofs == 2'd0);
      default:                             ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/byte_strobe_ram.sv
// Depth x WordSize x ByteBits storage with per-lane write enables and a registered read port.
module byte_strobe_ram #(
  parameter  int unsigned Depth    = 1024,
  parameter  int unsigned WordSize = 4,
  parameter  int unsigned ByteBits = 8,
  localparam int unsigned IdxW     = $clog2(Depth),
  localparam int unsigned WordW    = WordSize * ByteBits
) (
  input  logic                clk,
  input  logic                rd_en_i,
  input  logic [IdxW-1:0]     rd_idx_i,
  output logic [WordW-1:0]    rd_data_o,
  input  logic [WordSize-1:0] wr_be_i,
  input  logic [IdxW-1:0]     wr_idx_i,
  input  logic [WordW-1:0]    wr_data_i
);

  logic [WordSize-1:0][ByteBits-1:0] mem_q [Depth];
  logic [WordW-1:0]                  rd_data_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < WordSize; i++) begin
      if (wr_be_i[i]) begin
        mem_q[wr_idx_i][i] <= wr_data_i[i*ByteBits +: ByteBits];
      end
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/data_ram_responder.sv
// Memory-side responder of the CPU RAM bundle: byte-strobed word RAM behind valid/ready with
// Latency wait states. Define STROBE_CHECK_EN to reject illegal or misaligned write strobes.
module data_ram_responder
  import ram_bundle_pkg::*;
#(
  parameter int unsigned Depth   = 1024,
  parameter int unsigned Latency = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 read_enable,
  input  logic                 write_enable,
  input  logic [AddrWidth-1:0] address,
  input  logic [DataWidth-1:0] write_data,
  input  logic [WordSize-1:0]  write_strobe,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DataWidth-1:0] read_data,
  output logic                 rsp_error
);

  localparam int unsigned OfsW = $clog2(WordSize);
  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Latency) + 1;

  state_e               state_q;
  logic [CntW-1:0]      cnt_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_error_q;
  logic [DataWidth-1:0] read_data_q;
  logic [DataWidth-1:0] wdata_q;
  logic [IdxW-1:0]      idx_q;
  logic [WordSize-1:0]  strb_q;
  logic                 op_rd_q;
  logic                 op_wr_q;
  logic                 err_q;

  logic                 accept_c;
  logic                 is_rd_c;
  logic                 is_wr_c;
  logic                 range_err_c;
  logic                 strb_err_c;
  logic                 commit_c;
  logic [IdxW-1:0]      req_idx_c;
  logic [WordSize-1:0]  ram_be_c;
  logic [DataWidth-1:0] ram_rdata;

  assign accept_c    = req_valid & req_ready_q;
  assign is_rd_c     = read_enable;
  assign is_wr_c     = write_enable & ~read_enable;
  assign req_idx_c   = address[IdxW+OfsW-1:OfsW];
  assign range_err_c = |address[AddrWidth-1:IdxW+OfsW];

`ifdef STROBE_CHECK_EN
  assign strb_err_c = is_wr_c & ~strobe_legal(write_strobe, address[1:0]);
`else
  logic unused_ofs_c;
  assign unused_ofs_c = ^address[OfsW-1:0];
  assign strb_err_c   = 1'b0;
`endif

  // The write lands on the last wait-state edge; errored writes never reach the array.
  assign commit_c = (state_q == WAIT) && (cnt_q == '0) && op_wr_q && !err_q;
  assign ram_be_c = commit_c ? strb_q : '0;

  // Reads are fetched at acceptance so the word is ready by the last wait state.
  byte_strobe_ram #(
    .Depth    (Depth),
    .WordSize (WordSize),
    .ByteBits (ByteBits)
  ) u_ram (
    .clk       (clk),
    .rd_en_i   (accept_c & is_rd_c),
    .rd_idx_i  (req_idx_c),
    .rd_data_o (ram_rdata),
    .wr_be_i   (ram_be_c),
    .wr_idx_i  (idx_q),
    .wr_data_i (wdata_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      read_data_q <= '0;
      wdata_q     <= '0;
      idx_q       <= '0;
      strb_q      <= '0;
      op_rd_q     <= 1'b0;
      op_wr_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            idx_q       <= req_idx_c;
            wdata_q     <= write_data;
            strb_q      <= write_strobe;
            op_rd_q     <= is_rd_c;
            op_wr_q     <= is_wr_c;
            err_q       <= range_err_c | strb_err_c;
            cnt_q       <= CntW'(Latency - 1);
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_valid_q <= 1'b1;
            rsp_error_q <= err_q;
            read_data_q <= (op_rd_q && !err_q) ? ram_rdata : '0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            read_data_q <= '0;
            req_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign read_data = read_data_q;
  assign rsp_error = rsp_error_q;

endmodule

// File: tb/tb_data_ram_responder.sv
// Scoreboard bench for data_ram_responder: instance 0 runs Latency=1, instance 1 Latency=3.
module tb_data_ram_responder;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid    [2];
  logic        req_ready    [2];
  logic        read_enable  [2];
  logic        write_enable [2];
  logic [31:0] address      [2];
  logic [31:0] write_data   [2];
  logic [3:0]  write_strobe [2];
  logic        rsp_valid    [2];
  logic        rsp_ready    [2];
  logic [31:0] read_data    [2];
  logic        rsp_error    [2];

  exp_t sb0[$];
  exp_t sb1[$];
  int   n_vec = 0;
  int   n_err = 0;

  data_ram_responder #(.Depth(1024), .Latency(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .read_enable(read_enable[0]), .write_enable(write_enable[0]),
    .address(address[0]), .write_data(write_data[0]), .write_strobe(write_strobe[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .read_data(read_data[0]), .rsp_error(rsp_error[0])
  );

  data_ram_responder #(.Depth(1024), .Latency(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .read_enable(read_enable[1]), .write_enable(write_enable[1]),
    .address(address[1]), .write_data(write_data[1]), .write_strobe(write_strobe[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .read_data(read_data[1]), .rsp_error(rsp_error[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop and compare on every response handshake.
  task automatic mon(input int d);
    exp_t e;
    n_vec++;
    if ((d == 0 && sb0.size() == 0) || (d == 1 && sb1.size() == 0)) begin
      n_err++;
      $display("FAIL unexpected_rsp dut%0d: got data %h err %b with nothing expected",
               d, read_data[d], rsp_error[d]);
    end else begin
      if (d == 0) e = sb0.pop_front();
      else        e = sb1.pop_front();
      if (read_data[d] !== e.data || rsp_error[d] !== e.err) begin
        n_err++;
        $display("FAIL rsp dut%0d: got data %h err %b expected data %h err %b",
                 d, read_data[d], rsp_error[d], e.data, e.err);
      end
    end
  endtask

  always @(negedge clk) if (rsp_valid[0] === 1'b1 && rsp_ready[0]) mon(0);
  always @(negedge clk) if (rsp_valid[1] === 1'b1 && rsp_ready[1]) mon(1);

  task automatic issue(input int d, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] s,
                       input logic [31:0] ed, input logic ee, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    read_enable[d]  = rd;
    write_enable[d] = wr;
    address[d]      = a;
    write_data[d]   = wd;
    write_strobe[d] = s;
    req_valid[d]    = 1'b1;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: req_ready stuck at %b, required 1", d, req_ready[d]);
    end else if (push) begin
      if (d == 0) sb0.push_back('{data: ed, err: ee});
      else        sb1.push_back('{data: ed, err: ee});
    end
    @(posedge clk);
    #1;
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (rsp_valid[d] !== 1'b1 && cyc < 20);
  endtask

  task automatic drain(input int d);
    int n;
    n = 0;
    while (((d == 0) ? sb0.size() : sb1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_vec++;
      n_err++;
      $display("FAIL drain_timeout dut%0d: responses still pending, required none", d);
    end
    @(negedge clk);
  endtask

  logic [31:0] exp_30_err;
  logic [31:0] exp_30_data;

  initial begin
    int cyc;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; read_enable[d] = 1'b0; write_enable[d] = 1'b0;
      address[d] = '0; write_data[d] = '0; write_strobe[d] = '0; rsp_ready[d] = 1'b1;
    end
`ifdef STROBE_CHECK_EN
    exp_30_err  = 32'd1;
    exp_30_data = 32'hA1B2C3D4;
`else
    exp_30_err  = 32'd0;
    exp_30_data = 32'hA1FFEED4;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_read_data", read_data[d], 32'd0);
      chk("rst_rsp_error", 32'(rsp_error[d]), 32'd0);
    end
    rst = 1'b0;

    // Latency=1: full-word write then read with response two cycles after acceptance.
    issue(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 1);
    issue(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 1);
    wait_rsp(0, cyc);
    chk("latency_l1", 32'(cyc), 32'd2);

    // Single-lane merge into a preloaded word.
    issue(0, 0, 1, 32'h20, 32'h11223344, 4'b1111, 32'h0, 0, 1);
    issue(0, 0, 1, 32'h21, 32'h0000AB00, 4'b0010, 32'h0, 0, 1);
    issue(0, 1, 0, 32'h20, 32'h0, 4'b0000, 32'h1122AB44, 0, 1);

    // Out-of-range accesses alias word 0 but must neither write nor read it.
    issue(0, 0, 1, 32'h0, 32'hCAFEF00D, 4'b1111, 32'h0, 0, 1);
    issue(0, 1, 0, 32'h1000, 32'h0, 4'b0000, 32'h0, 1, 1);
    issue(0, 0, 1, 32'h1000, 32'h55555555, 4'b1111, 32'h0, 1, 1);
    issue(0, 1, 0, 32'h0, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 1);

    // Empty strobe, no-op request, and read+write treated as read.
    issue(0, 0, 1, 32'h10, 32'h12345678, 4'b0000, 32'h0, 0, 1);
    issue(0, 0, 0, 32'h10, 32'h0, 4'b0000, 32'h0, 0, 1);
    issue(0, 1, 1, 32'h10, 32'h0, 4'b1111, 32'hDEADBEEF, 0, 1);
    issue(0, 1, 0, 32'h10, 32'h0, 4'b0000, 32'hDEADBEEF, 0, 1);

    // Middle-lane strobe 0110: rejected with the check enabled, applied otherwise.
    issue(0, 0, 1, 32'h30, 32'hA1B2C3D4, 4'b1111, 32'h0, 0, 1);
    issue(0, 0, 1, 32'h30, 32'h00FFEE00, 4'b0110, 32'h0, exp_30_err[0], 1);
    issue(0, 1, 0, 32'h30, 32'h0, 4'b0000, exp_30_data, 0, 1);
    drain(0);

    // Latency=3: write/read, response four cycles after acceptance.
    issue(1, 0, 1, 32'h40, 32'h01020304, 4'b1111, 32'h0, 0, 1);
    issue(1, 1, 0, 32'h40, 32'h0, 4'b0000, 32'h01020304, 0, 1);
    wait_rsp(1, cyc);
    chk("latency_l3", 32'(cyc), 32'd4);
    drain(1);

    // Back-pressure: response held stable, no new acceptance while stalled.
    rsp_ready[1] = 1'b0;
    issue(1, 1, 0, 32'h40, 32'h0, 4'b0000, 32'h01020304, 0, 1);
    wait_rsp(1, cyc);
    chk("latency_stall", 32'(cyc), 32'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_data", read_data[1], 32'h01020304);
      chk("stall_req_ready", 32'(req_ready[1]), 32'd0);
      chk("stall_rsp_valid", 32'(rsp_valid[1]), 32'd1);
    end
    @(posedge clk);
    #1;
    rsp_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_hs_req_ready", 32'(req_ready[1]), 32'd1);
    chk("post_hs_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    drain(1);

    // Reset during WAIT discards the pending read; stored data survives.
    issue(1, 1, 0, 32'h40, 32'h0, 4'b0000, 32'h0, 0, 0);
    rst = 1'b1;
    #1;
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid[1]), 32'd0);
    end
    issue(1, 1, 0, 32'h40, 32'h0, 4'b0000, 32'h01020304, 0, 1);
    issue(0, 1, 0, 32'h20, 32'h0, 4'b0000, 32'h1122AB44, 0, 1);
    drain(1);
    drain(0);
    chk("sb0_empty", 32'(sb0.size()), 32'd0);
    chk("sb1_empty", 32'(sb1.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
